// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_W    = 4;

  // Register 0 reads as zero and can never carry a pending write.
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One register's pending-write countdown: decrements to zero, reloads with max(dec, load_val).
module sb_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             next_zero
);

  logic [CNT_W-1:0] dec;
  logic [CNT_W-1:0] cnt_d;

  // Saturating decrement, then keep the longer of the two latencies on a new write.
  always_comb begin
    dec   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    cnt_d = dec;
    if (load && (load_val > dec)) begin
      cnt_d = load_val;
    end
  end

  assign next_zero = (cnt_d == '0);

  // Counter and its busy flag, both taken from the post-update value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      busy <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode interlock: per-register write scoreboard, stall/issue generation and halt drain.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_ALU  = 2,
  parameter int unsigned LAT_LOAD = 2,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_src1,
  input  logic                id_src1_used,
  input  logic [REG_W-1:0]    id_src2,
  input  logic                id_src2_used,
  input  logic [REG_W-1:0]    id_dst,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                id_halt,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic                halted,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] next_zero;
  logic [CNT_W-1:0]    load_val;
  logic                wr_en;
  logic                src1_hit;
  logic                src2_hit;
  logic                hazard;
  logic                drained;
  state_t              state_q;
  state_t              state_d;

  // Register 0 has no counter: never pending, never busy.
  assign cnt[0]       = '0;
  assign next_zero[0] = 1'b1;
  assign busy_vec[0]  = 1'b0;

  assign load_val = id_memread ? CNT_W'(LAT_LOAD) : CNT_W'(LAT_ALU);
  // HLT never writes, even if decode flags a destination.
  assign wr_en    = issue && id_regwrite && !id_halt;

  // One countdown per architectural register 1..15.
  for (genvar r = 1; r < 16; r++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .load      (wr_en && (id_dst == REG_W'(r))),
      .load_val  (load_val),
      .cnt       (cnt[r]),
      .busy      (busy_vec[r]),
      .next_zero (next_zero[r])
    );
  end

  // Source operand is not yet readable from the register file.
  assign src1_hit = id_src1_used && (id_src1 != ZERO_REG) && (cnt[id_src1] != '0);
  assign src2_hit = id_src2_used && (id_src2 != ZERO_REG) && (cnt[id_src2] != '0);
  assign hazard   = src1_hit || src2_hit;
  assign drained  = &next_zero;

  // Next-state and stall/issue; flush overrides hazard, reset silences both.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      RUN: begin
        stall = id_valid && hazard && !flush;
        issue = id_valid && !hazard && !flush;
        if (issue && id_halt) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (drained) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (rst) begin
      stall = 1'b0;
      issue = 1'b0;
    end
  end

  // FSM state and registered halted flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == HALTED);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: ready-cycle model of the scoreboard plus directed literal checks.
module tb_hazard_scoreboard;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src1;
  logic        id_src1_used;
  logic [3:0]  id_src2;
  logic        id_src2_used;
  logic [3:0]  id_dst;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_halt;
  logic        flush;
  logic        stall;
  logic        issue;
  logic        halted;
  logic [15:0] busy_vec;

  int errors = 0;
  int checks = 0;

  // Model: absolute cycle at which each register becomes readable in decode.
  int ready [16];
  int cyc         = 0;
  int halt_cyc    = -1;
  int drain_ready = 0;
  bit model_ok    = 1'b0;

  hazard_scoreboard #(
    .LAT_ALU  (LAT_ALU),
    .LAT_LOAD (LAT_LOAD),
    .CNT_W    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src1_used (id_src1_used),
    .id_src2      (id_src2),
    .id_src2_used (id_src2_used),
    .id_dst       (id_dst),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_halt      (id_halt),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .halted       (halted),
    .busy_vec     (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int max_ready();
    int m;
    m = 0;
    for (int i = 0; i < 16; i++) if (ready[i] > m) m = ready[i];
    return m;
  endfunction

  function automatic void m_out(output logic es, output logic ei);
    logic hz;
    logic run;
    hz  = (id_src1_used && (id_src1 != 4'd0) && (ready[id_src1] > cyc)) ||
          (id_src2_used && (id_src2 != 4'd0) && (ready[id_src2] > cyc));
    run = (halt_cyc < 0) || (cyc <= halt_cyc);
    if (rst) begin
      es = 1'b0;
      ei = 1'b0;
    end else if (!run) begin
      es = 1'b1;
      ei = 1'b0;
    end else begin
      es = id_valid && hz && !flush;
      ei = id_valid && !hz && !flush;
    end
  endfunction

  // Model update at each clock edge.
  always @(posedge clk) begin
    logic es;
    logic ei;
    int   lat;
    if (rst) begin
      for (int i = 0; i < 16; i++) ready[i] <= 0;
      halt_cyc    <= -1;
      drain_ready <= 0;
      model_ok    <= 1'b1;
    end else begin
      m_out(es, ei);
      if (ei) begin
        if (id_halt) begin
          halt_cyc    <= cyc;
          drain_ready <= max_ready();
        end else if (id_regwrite && (id_dst != 4'd0)) begin
          lat = id_memread ? LAT_LOAD : LAT_ALU;
          if (cyc + lat + 1 > ready[id_dst]) ready[id_dst] <= cyc + lat + 1;
        end
      end
    end
    cyc <= cyc + 1;
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic        es;
    logic        ei;
    logic        eh;
    logic [15:0] eb;
    if (model_ok) begin
      m_out(es, ei);
      eh = (halt_cyc >= 0) && (cyc >= halt_cyc + 2) && (cyc >= drain_ready);
      for (int i = 0; i < 16; i++) eb[i] = (ready[i] > cyc);
      chk("model_stall", stall, es);
      chk("model_issue", issue, ei);
      chk("model_halted", halted, eh);
      chk("model_busy_vec", busy_vec, eb);
    end
  end

  task automatic drv(input logic v, input logic [3:0] s1, input logic s1u,
                     input logic [3:0] s2, input logic s2u, input logic [3:0] d,
                     input logic rw, input logic mr, input logic h, input logic fl);
    id_valid = v;  id_src1 = s1;  id_src1_used = s1u;
    id_src2 = s2;  id_src2_used = s2u;  id_dst = d;
    id_regwrite = rw;  id_memread = mr;  id_halt = h;  flush = fl;
  endtask

  task automatic idle();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", stall, 0);
    chk("reset_issue", issue, 0);
    chk("reset_halted", halted, 0);
    chk("reset_busy", busy_vec, 0);
    nxt();
    rst = 1'b0;

    // Load-use: load r3, reader of r3 stalls two cycles.
    drv(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    @(negedge clk); chk("lduse_ld_issue", issue, 1); nxt();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("lduse_c1_stall", stall, 1); chk("lduse_c1_busy3", busy_vec[3], 1); nxt();
    @(negedge clk); chk("lduse_c2_stall", stall, 1); chk("lduse_c2_busy3", busy_vec[3], 1); nxt();
    @(negedge clk); chk("lduse_c3_issue", issue, 1); chk("lduse_c3_busy3", busy_vec[3], 0); nxt();
    idle(); nxt();

    // Writes to r0 and unused sources never hazard.
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk); chk("r0_wr_issue", issue, 1); nxt();
    drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("r0_rd_stall", stall, 0); chk("r0_rd_busy", busy_vec, 0); nxt();
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); nxt();
    drv(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("unused_src2_stall", stall, 0); chk("unused_src2_issue", issue, 1); nxt();
    idle(); nxt(); nxt();

    // WAW: load r7 then ALU r7 keeps the longer countdown.
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); nxt();
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    @(negedge clk); chk("waw_alu_issue", issue, 1); chk("waw_c1_busy7", busy_vec[7], 1); nxt();
    drv(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("waw_c2_stall", stall, 1); chk("waw_c2_busy7", busy_vec[7], 1); nxt();
    @(negedge clk); chk("waw_c3_issue", issue, 1); nxt();
    idle(); nxt();

    // Flush beats hazard and leaves the scoreboard untouched.
    drv(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); nxt();
    drv(1, 9, 1, 0, 0, 10, 1, 0, 0, 1);
    @(negedge clk); chk("flush_stall", stall, 0); chk("flush_issue", issue, 0); nxt();
    drv(1, 1, 1, 2, 1, 11, 1, 0, 0, 0);
    @(negedge clk); chk("flush_next_issue", issue, 1); chk("flush_busy10", busy_vec[10], 0); nxt();
    idle();
    @(negedge clk); chk("flush_busy11", busy_vec[11], 1); chk("flush_busy10_b", busy_vec[10], 0); nxt();
    nxt(); nxt();

    // Reset while a reader of r4 is stalled.
    drv(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); nxt();
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rsthz_stall", stall, 1); chk("rsthz_busy4", busy_vec[4], 1); nxt();
    rst = 1'b1;
    @(negedge clk); chk("rsthz_rst_stall", stall, 0); nxt();
    rst = 1'b0;
    @(negedge clk); chk("rsthz_after_stall", stall, 0); chk("rsthz_after_issue", issue, 1);
    chk("rsthz_after_busy", busy_vec, 0); nxt();
    idle(); nxt();

    // Halt with a pending write to r2.
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); nxt();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("halt_hlt_issue", issue, 1); nxt();
    drv(1, 1, 1, 0, 0, 6, 1, 0, 0, 0);
    @(negedge clk); chk("halt_c2_stall", stall, 1); chk("halt_c2_issue", issue, 0);
    chk("halt_c2_halted", halted, 0); nxt();
    @(negedge clk); chk("halt_c3_stall", stall, 1); chk("halt_c3_halted", halted, 1); nxt();
    @(negedge clk); chk("halt_c4_halted", halted, 1); nxt();
    rst = 1'b1; nxt();
    rst = 1'b0;
    @(negedge clk); chk("halt_rst_halted", halted, 0); chk("halt_rst_stall", stall, 0);
    chk("halt_rst_busy", busy_vec, 0); chk("halt_rst_issue", issue, 1); nxt();
    idle(); nxt(); nxt();

    // Halt on an empty scoreboard: RUN -> DRAIN -> HALTED.
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("ehalt_issue", issue, 1); nxt();
    idle();
    @(negedge clk); chk("ehalt_c1_stall", stall, 1); chk("ehalt_c1_halted", halted, 0); nxt();
    @(negedge clk); chk("ehalt_c2_halted", halted, 1); nxt();
    rst = 1'b1; nxt();
    rst = 1'b0; nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
